// File: rtl/scaler_pkg.sv
// Shared definitions for the scaler pipeline: bank ids, flag encodings,
// write-FSM states and a constant-width helper.
package scaler_pkg;

    localparam logic SW_PING = 1'b0;
    localparam logic SW_PONG = 1'b1;

    localparam logic FULL  = 1'b1;
    localparam logic EMPTY = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SOF_WAIT = 3'd1,
        ST_LINE     = 3'd2,
        ST_DROP     = 3'd3,
        ST_DONE     = 3'd4
    } vin_state_t;

    function automatic int CLOG2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/scaler_vin_mem.sv
// Two-bank ping-pong line RAM: per-bank full flags, independent write/read
// bank pointers and a two-stage registered read port.
module scaler_vin_mem
    import scaler_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_close,
    input  logic              rd_release,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              wr_full,
    output logic              rd_full
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [0:2*DEPTH-1];
    logic [1:0]        full;
    logic              wr_bank;
    logic              rd_bank;
    logic [DATA_W-1:0] rd_q;
    logic              rd_vld;

    assign wr_full = full[wr_bank];
    assign rd_full = full[rd_bank];

    always_ff @(posedge clk) begin
        if (wr_en) mem[{wr_bank, wr_addr}] <= wr_data;
        if (rd_en) rd_q <= mem[{rd_bank, rd_addr}];
    end

    // A close and a release never target the same bank: close only hits an
    // empty bank, release only a full one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full    <= {EMPTY, EMPTY};
            wr_bank <= SW_PING;
            rd_bank <= SW_PING;
        end else if (clr) begin
            full    <= {EMPTY, EMPTY};
            wr_bank <= SW_PING;
            rd_bank <= SW_PING;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (wr_close && wr_bank == 1'(b))
                    full[b] <= FULL;
                else if (rd_release && rd_bank == 1'(b))
                    full[b] <= EMPTY;
            end
            if (wr_close)   wr_bank <= (wr_bank == SW_PING) ? SW_PONG : SW_PING;
            if (rd_release) rd_bank <= (rd_bank == SW_PING) ? SW_PONG : SW_PING;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_vld  <= 1'b0;
            rd_data <= '0;
        end else if (clr) begin
            rd_vld  <= 1'b0;
            rd_data <= '0;
        end else begin
            rd_vld <= rd_en;
            if (rd_vld) rd_data <= rd_q;
        end
    end

endmodule

// File: rtl/scaler_vin.sv
// Scaler input stage: stream-to-line-buffer writer with ping-pong handoff.
// Define SCALER_VIN_ERR_CNT_EN to add the saturating core_err_cnt output.
module scaler_vin
    import scaler_pkg::*;
#(
    parameter int PIXEL_BITWIDTH     = 8,
    parameter int PIXEL_NUM          = 1,
    parameter int IMG_H_MAX          = 1920,
    parameter int IMG_V_MAX          = 1080,
    parameter int IMG_H_BITWIDTH     = CLOG2(IMG_H_MAX),
    parameter int IMG_V_BITWIDTH     = CLOG2(IMG_V_MAX),
    parameter int BRAM_ADDR_BITWIDTH = 11
) (
    input  logic                                core_clk,
    input  logic                                core_rst,
    input  logic                                core_start,
    input  logic [IMG_H_BITWIDTH-1:0]           core_arg_img_src_h,
    input  logic [IMG_V_BITWIDTH-1:0]           core_arg_img_src_v,
    input  logic                                s_axis_valid,
    output logic                                s_axis_ready,
    input  logic [PIXEL_NUM*PIXEL_BITWIDTH-1:0] s_axis_pixel,
    input  logic                                s_axis_sof,
    input  logic                                s_axis_eol,
    input  logic                                core_rd_en,
    input  logic [BRAM_ADDR_BITWIDTH-1:0]       core_rd_addr,
    output logic [PIXEL_NUM*PIXEL_BITWIDTH-1:0] core_rd_pixel,
    output logic                                core_line_valid,
    output logic [IMG_V_BITWIDTH-1:0]           core_line_num,
    input  logic                                core_line_done,
    output logic                                core_frame_done,
    output logic                                core_err_line
`ifdef SCALER_VIN_ERR_CNT_EN
    ,
    output logic [15:0]                         core_err_cnt
`endif
);

    localparam int DATA_W = PIXEL_NUM * PIXEL_BITWIDTH;
    localparam logic [BRAM_ADDR_BITWIDTH-1:0] A_ONE = BRAM_ADDR_BITWIDTH'(1);
    localparam logic [IMG_V_BITWIDTH-1:0]     V_ONE = IMG_V_BITWIDTH'(1);

    vin_state_t state, state_nxt;

    logic [BRAM_ADDR_BITWIDTH-1:0] bpl, wr_addr, cur_addr, last_addr;
    logic [IMG_V_BITWIDTH-1:0]     src_v, lines_wr;
    logic [IMG_V_BITWIDTH:0]       lines_nxt;
    logic [IMG_H_BITWIDTH-1:0]     bpl_arg;
    logic wr_full, rd_full;
    logic accept, wbeat, at_last, close, err_evt, release_line, frame_end;

    assign bpl_arg   = core_arg_img_src_h / IMG_H_BITWIDTH'(PIXEL_NUM);
    assign last_addr = bpl - A_ONE;
    assign accept    = s_axis_valid & s_axis_ready;

    // The sof beat is written from SOF_WAIT straight to address 0.
    assign cur_addr = (state == ST_LINE) ? wr_addr : '0;
    assign wbeat    = accept & ~core_start &
                      ((state == ST_LINE) | ((state == ST_SOF_WAIT) & s_axis_sof));
    assign at_last  = (cur_addr == last_addr);
    assign close    = wbeat & (s_axis_eol | at_last);
    assign err_evt  = close & (s_axis_eol ^ at_last);
    assign lines_nxt = {1'b0, lines_wr} + {{IMG_V_BITWIDTH{1'b0}}, 1'b1};

    assign release_line = core_line_done & rd_full & ~core_start;
    assign frame_end    = release_line & (core_line_num == src_v - V_ONE);

    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (core_start)
            state_nxt = ST_SOF_WAIT;
        else if (frame_end)
            state_nxt = ST_IDLE;
        else begin
            case (state)
                ST_SOF_WAIT, ST_LINE: begin
                    if (close) begin
                        if (!s_axis_eol)                    state_nxt = ST_DROP;
                        else if (lines_nxt < {1'b0, src_v}) state_nxt = ST_LINE;
                        else                                state_nxt = ST_DONE;
                    end else if (wbeat) begin
                        state_nxt = ST_LINE;
                    end
                end
                ST_DROP: begin
                    if (accept && s_axis_eol)
                        state_nxt = (lines_wr < src_v) ? ST_LINE : ST_DONE;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        s_axis_ready = 1'b0;
        case (state)
            ST_SOF_WAIT, ST_DROP: s_axis_ready = 1'b1;
            ST_LINE:              s_axis_ready = ~wr_full;
            default:              s_axis_ready = 1'b0;
        endcase
    end

    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            bpl             <= '0;
            src_v           <= '0;
            wr_addr         <= '0;
            lines_wr        <= '0;
            core_line_num   <= '0;
            core_err_line   <= 1'b0;
            core_frame_done <= 1'b0;
        end else if (core_start) begin
            bpl             <= BRAM_ADDR_BITWIDTH'(bpl_arg);
            src_v           <= core_arg_img_src_v;
            wr_addr         <= '0;
            lines_wr        <= '0;
            core_line_num   <= '0;
            core_err_line   <= 1'b0;
            core_frame_done <= 1'b0;
        end else begin
            core_frame_done <= frame_end;
            if (wbeat)        wr_addr       <= close ? '0 : cur_addr + A_ONE;
            if (close)        lines_wr      <= lines_wr + V_ONE;
            if (release_line) core_line_num <= core_line_num + V_ONE;
            if (err_evt)      core_err_line <= 1'b1;
        end
    end

`ifdef SCALER_VIN_ERR_CNT_EN
    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst)
            core_err_cnt <= '0;
        else if (core_start)
            core_err_cnt <= '0;
        else if (err_evt && core_err_cnt != 16'hFFFF)
            core_err_cnt <= core_err_cnt + 16'd1;
    end
`else
    // Without the counter only the sticky core_err_line reports bad lines.
`endif

    scaler_vin_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (BRAM_ADDR_BITWIDTH)
    ) u_mem (
        .clk        (core_clk),
        .rst        (core_rst),
        .clr        (core_start),
        .wr_en      (wbeat),
        .wr_addr    (cur_addr),
        .wr_data    (s_axis_pixel),
        .wr_close   (close),
        .rd_release (release_line),
        .rd_en      (core_rd_en),
        .rd_addr    (core_rd_addr),
        .rd_data    (core_rd_pixel),
        .wr_full    (wr_full),
        .rd_full    (rd_full)
    );

    assign core_line_valid = rd_full;

endmodule

// File: tb/tb_scaler_vin.sv
// Directed bench for scaler_vin: one task per scenario, inline checks.
module tb_scaler_vin;

    logic        clk;
    logic        rst;
    logic        start;
    logic [10:0] src_h;
    logic [10:0] src_v;
    logic        valid;
    logic        ready;
    logic [7:0]  pixel;
    logic        sof;
    logic        eol;
    logic        rd_en;
    logic [10:0] rd_addr;
    logic [7:0]  rd_pixel;
    logic        line_valid;
    logic [10:0] line_num;
    logic        line_done;
    logic        frame_done;
    logic        err_line;
`ifdef SCALER_VIN_ERR_CNT_EN
    logic [15:0] err_cnt;
`endif

    int checks;
    int errors;

    scaler_vin dut (
        .core_clk           (clk),
        .core_rst           (rst),
        .core_start         (start),
        .core_arg_img_src_h (src_h),
        .core_arg_img_src_v (src_v),
        .s_axis_valid       (valid),
        .s_axis_ready       (ready),
        .s_axis_pixel       (pixel),
        .s_axis_sof         (sof),
        .s_axis_eol         (eol),
        .core_rd_en         (rd_en),
        .core_rd_addr       (rd_addr),
        .core_rd_pixel      (rd_pixel),
        .core_line_valid    (line_valid),
        .core_line_num      (line_num),
        .core_line_done     (line_done),
        .core_frame_done    (frame_done),
        .core_err_line      (err_line)
`ifdef SCALER_VIN_ERR_CNT_EN
        ,
        .core_err_cnt       (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] px(input int l, input int i);
        return 8'((l * 16 + i + 3) & 255);
    endfunction

    task automatic do_start(input int h, input int v);
        start = 1'b1; src_h = 11'(h); src_v = 11'(v);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] p, input logic s, input logic e);
        int n;
        n = 0;
        valid = 1'b1; pixel = p; sof = s; eol = e;
        while (ready !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL send_timeout ready=%b required 1", ready);
        end
        @(posedge clk); #1;
        valid = 1'b0; sof = 1'b0; eol = 1'b0;
    endtask

    task automatic send_line(input int l, input int n);
        for (int i = 0; i < n; i++) send(px(l, i), i == 0, i == n - 1);
    endtask

    task automatic rd(input int a, output logic [7:0] d);
        rd_en = 1'b1; rd_addr = 11'(a);
        @(posedge clk); #1;
        rd_en = 1'b0;
        @(posedge clk); #1;
        d = rd_pixel;
    endtask

    task automatic pulse_done();
        line_done = 1'b1;
        @(posedge clk); #1;
        line_done = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (ready !== 1'b0)      begin errors++; $display("FAIL rst_ready got %b exp 0", ready); end
        checks++; if (rd_pixel !== 8'h00)  begin errors++; $display("FAIL rst_rd_pixel got %h exp 00", rd_pixel); end
        checks++; if (line_valid !== 1'b0) begin errors++; $display("FAIL rst_line_valid got %b exp 0", line_valid); end
        checks++; if (line_num !== 11'd0)  begin errors++; $display("FAIL rst_line_num got %0d exp 0", line_num); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_frame_done got %b exp 0", frame_done); end
        checks++; if (err_line !== 1'b0)   begin errors++; $display("FAIL rst_err_line got %b exp 0", err_line); end
    endtask

    task automatic test_basic_frame();
        logic [7:0] d;
        do_start(8, 2);
        for (int i = 0; i < 7; i++) send(px(0, i), i == 0, 1'b0);
        checks++; if (line_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_early got %b exp 0", line_valid); end
        send(px(0, 7), 1'b0, 1'b1);
        checks++; if (line_valid !== 1'b1) begin errors++; $display("FAIL basic_valid_rise got %b exp 1", line_valid); end
        checks++; if (line_num !== 11'd0)  begin errors++; $display("FAIL basic_num0 got %0d exp 0", line_num); end
        send_line(1, 8);
        rd_en = 1'b1; rd_addr = 11'd0;
        @(posedge clk); #1;
        rd_en = 1'b0;
        checks++; if (rd_pixel !== 8'h00) begin errors++; $display("FAIL basic_rd_lat1 got %h exp 00", rd_pixel); end
        @(posedge clk); #1;
        checks++; if (rd_pixel !== px(0, 0)) begin errors++; $display("FAIL basic_rd_lat2 got %h exp %h", rd_pixel, px(0, 0)); end
        @(posedge clk); #1;
        checks++; if (rd_pixel !== px(0, 0)) begin errors++; $display("FAIL basic_rd_hold got %h exp %h", rd_pixel, px(0, 0)); end
        for (int a = 1; a < 8; a++) begin
            rd(a, d);
            checks++; if (d !== px(0, a)) begin errors++; $display("FAIL basic_l0_px%0d got %h exp %h", a, d, px(0, a)); end
        end
        pulse_done();
        checks++; if (line_valid !== 1'b1) begin errors++; $display("FAIL basic_valid_l1 got %b exp 1", line_valid); end
        checks++; if (line_num !== 11'd1)  begin errors++; $display("FAIL basic_num1 got %0d exp 1", line_num); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL basic_fd_early got %b exp 0", frame_done); end
        for (int a = 0; a < 8; a++) begin
            rd(a, d);
            checks++; if (d !== px(1, a)) begin errors++; $display("FAIL basic_l1_px%0d got %h exp %h", a, d, px(1, a)); end
        end
        pulse_done();
        checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL basic_fd_pulse got %b exp 1", frame_done); end
        @(posedge clk); #1;
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL basic_fd_end got %b exp 0", frame_done); end
        checks++; if (line_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_end got %b exp 0", line_valid); end
    endtask

    task automatic test_backpressure();
        logic [7:0] d;
        int hi;
        do_start(8, 3);
        send_line(0, 8);
        send_line(1, 8);
        valid = 1'b1; pixel = px(2, 0); sof = 1'b0; eol = 1'b0;
        hi = 0;
        for (int c = 0; c < 30; c++) begin
            if (ready !== 1'b0) hi++;
            @(posedge clk); #1;
        end
        checks++; if (hi != 0) begin errors++; $display("FAIL bp_stall ready high %0d cycles exp 0", hi); end
        pulse_done();
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL bp_resume got %b exp 1", ready); end
        send(px(2, 0), 1'b0, 1'b0);
        for (int i = 1; i < 8; i++) send(px(2, i), 1'b0, i == 7);
        rd(5, d);
        checks++; if (d !== px(1, 5)) begin errors++; $display("FAIL bp_l1_px5 got %h exp %h", d, px(1, 5)); end
        pulse_done();
        checks++; if (line_num !== 11'd2) begin errors++; $display("FAIL bp_num2 got %0d exp 2", line_num); end
        for (int a = 0; a < 8; a++) begin
            rd(a, d);
            checks++; if (d !== px(2, a)) begin errors++; $display("FAIL bp_l2_px%0d got %h exp %h", a, d, px(2, a)); end
        end
        pulse_done();
        checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL bp_fd got %b exp 1", frame_done); end
    endtask

    task automatic test_short_line();
        logic [7:0] d;
        do_start(8, 2);
        for (int i = 0; i < 4; i++) send(px(3, i), i == 0, 1'b0);
        checks++; if (err_line !== 1'b0) begin errors++; $display("FAIL short_err_early got %b exp 0", err_line); end
        send(px(3, 4), 1'b0, 1'b1);
        checks++; if (err_line !== 1'b1)   begin errors++; $display("FAIL short_err got %b exp 1", err_line); end
        checks++; if (line_valid !== 1'b1) begin errors++; $display("FAIL short_valid got %b exp 1", line_valid); end
        send_line(4, 8);
        rd(4, d);
        checks++; if (d !== px(3, 4)) begin errors++; $display("FAIL short_l0_px4 got %h exp %h", d, px(3, 4)); end
        pulse_done();
        checks++; if (line_num !== 11'd1) begin errors++; $display("FAIL short_num1 got %0d exp 1", line_num); end
        rd(0, d);
        checks++; if (d !== px(4, 0)) begin errors++; $display("FAIL short_align0 got %h exp %h", d, px(4, 0)); end
        rd(7, d);
        checks++; if (d !== px(4, 7)) begin errors++; $display("FAIL short_align7 got %h exp %h", d, px(4, 7)); end
        checks++; if (err_line !== 1'b1) begin errors++; $display("FAIL short_err_sticky got %b exp 1", err_line); end
`ifdef SCALER_VIN_ERR_CNT_EN
        checks++; if (err_cnt !== 16'd1) begin errors++; $display("FAIL short_err_cnt got %0d exp 1", err_cnt); end
`endif
        pulse_done();
    endtask

    task automatic test_long_line();
        logic [7:0] d;
        do_start(8, 2);
        send_line(5, 11);
        checks++; if (err_line !== 1'b1)   begin errors++; $display("FAIL long_err got %b exp 1", err_line); end
        checks++; if (line_valid !== 1'b1) begin errors++; $display("FAIL long_valid got %b exp 1", line_valid); end
        checks++; if (ready !== 1'b1)      begin errors++; $display("FAIL long_ready got %b exp 1", ready); end
        send_line(6, 8);
        rd(7, d);
        checks++; if (d !== px(5, 7)) begin errors++; $display("FAIL long_l0_px7 got %h exp %h", d, px(5, 7)); end
        pulse_done();
        rd(0, d);
        checks++; if (d !== px(6, 0)) begin errors++; $display("FAIL long_l1_px0 got %h exp %h", d, px(6, 0)); end
        rd(2, d);
        checks++; if (d !== px(6, 2)) begin errors++; $display("FAIL long_l1_px2 got %h exp %h", d, px(6, 2)); end
`ifdef SCALER_VIN_ERR_CNT_EN
        checks++; if (err_cnt !== 16'd1) begin errors++; $display("FAIL long_err_cnt got %0d exp 1", err_cnt); end
`endif
        pulse_done();
    endtask

    task automatic test_pre_sof();
        logic [7:0] d;
        do_start(8, 1);
        for (int i = 0; i < 3; i++) send(8'hE0 + 8'(i), 1'b0, 1'b0);
        checks++; if (line_valid !== 1'b0) begin errors++; $display("FAIL presof_valid got %b exp 0", line_valid); end
        send_line(7, 8);
        rd(0, d);
        checks++; if (d !== px(7, 0)) begin errors++; $display("FAIL presof_px0 got %h exp %h", d, px(7, 0)); end
        rd(3, d);
        checks++; if (d !== px(7, 3)) begin errors++; $display("FAIL presof_px3 got %h exp %h", d, px(7, 3)); end
        pulse_done();
        checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL presof_fd got %b exp 1", frame_done); end
    endtask

    task automatic test_restart();
        logic [7:0] d;
        do_start(8, 3);
        send_line(8, 6);
        rd(2, d);
        checks++; if (d !== px(8, 2)) begin errors++; $display("FAIL rs_pre_px2 got %h exp %h", d, px(8, 2)); end
        for (int i = 0; i < 3; i++) send(px(9, i), 1'b0, 1'b0);
        do_start(8, 1);
        checks++; if (ready !== 1'b1)      begin errors++; $display("FAIL rs_ready got %b exp 1", ready); end
        checks++; if (rd_pixel !== 8'h00)  begin errors++; $display("FAIL rs_rd_pixel got %h exp 00", rd_pixel); end
        checks++; if (line_valid !== 1'b0) begin errors++; $display("FAIL rs_valid got %b exp 0", line_valid); end
        checks++; if (line_num !== 11'd0)  begin errors++; $display("FAIL rs_num got %0d exp 0", line_num); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rs_fd got %b exp 0", frame_done); end
        checks++; if (err_line !== 1'b0)   begin errors++; $display("FAIL rs_err got %b exp 0", err_line); end
`ifdef SCALER_VIN_ERR_CNT_EN
        checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL rs_err_cnt got %0d exp 0", err_cnt); end
`endif
        send_line(10, 8);
        rd(0, d);
        checks++; if (d !== px(10, 0)) begin errors++; $display("FAIL rs_px0 got %h exp %h", d, px(10, 0)); end
        rd(7, d);
        checks++; if (d !== px(10, 7)) begin errors++; $display("FAIL rs_px7 got %h exp %h", d, px(10, 7)); end
        pulse_done();
        checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL rs_fd_end got %b exp 1", frame_done); end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; start = 1'b0; src_h = '0; src_v = '0;
        valid = 1'b0; pixel = '0; sof = 1'b0; eol = 1'b0;
        rd_en = 1'b0; rd_addr = '0; line_done = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_short_line();
        test_long_line();
        test_pre_sof();
        test_restart();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
